// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and flag bundle for alu_core.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

endpackage

// File: rtl/alu_shifter.sv
// Logical shifter for alu_core: one-bit step by default, full barrel shift when
// ALU_BARREL_EN is defined. Reports the last bit shifted out and the OR of all lost bits.
module alu_shifter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         value_i,
  input  logic                     right_i,
`ifdef ALU_BARREL_EN
  input  logic [$clog2(WIDTH)-1:0] amount_i,
`endif
  output logic [WIDTH-1:0]         shifted_o,
  output logic                     last_o,
  output logic                     lost_o
);

`ifdef ALU_BARREL_EN
  always_comb begin
    shifted_o = right_i ? (value_i >> amount_i) : (value_i << amount_i);
    last_o    = 1'b0;
    lost_o    = 1'b0;
    // Amounts beyond WIDTH only shift out zeros, so they never match an index here.
    for (int i = 0; i < WIDTH; i++) begin
      if (right_i) begin
        if (i == int'(amount_i) - 1) last_o = value_i[i];
        if (i < int'(amount_i))      lost_o = lost_o | value_i[i];
      end else begin
        if (i == WIDTH - int'(amount_i))  last_o = value_i[i];
        if (i + int'(amount_i) >= WIDTH)  lost_o = lost_o | value_i[i];
      end
    end
  end
`else
  always_comb begin
    shifted_o = right_i ? {1'b0, value_i[WIDTH-1:1]} : {value_i[WIDTH-2:0], 1'b0};
    last_o    = right_i ? value_i[0] : value_i[WIDTH-1];
    lost_o    = last_o;
  end
`endif

endmodule

// File: rtl/alu_core.sv
// Handshaked WIDTH-bit ALU with registered result and flags. Shifts are iterative
// (one bit per cycle) unless ALU_BARREL_EN selects the single-cycle barrel shifter.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int MSB     = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;

  logic               accept;
  logic               go_shift;
  logic [SHAMT_W-1:0] amt_in;

  logic [WIDTH-1:0] opnd_b;
  logic             cin_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] imm_res;
  logic             imm_carry, imm_ovf;
  flags_t           imm_flags;

  logic [WIDTH-1:0] sh_val;
  logic             sh_last, sh_lost;

  assign amt_in = b[SHAMT_W-1:0];
  assign accept = in_valid && in_ready;

`ifdef ALU_BARREL_EN
  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .value_i   (a),
    .right_i   (op == OP_SHR),
    .amount_i  (amt_in),
    .shifted_o (sh_val),
    .last_o    (sh_last),
    .lost_o    (sh_lost)
  );

  assign go_shift = 1'b0;
`else
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               shr_q, sticky_q;
  logic               last_step;
  flags_t             fin_flags;

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .value_i   (work_q),
    .right_i   (shr_q),
    .shifted_o (sh_val),
    .last_o    (sh_last),
    .lost_o    (sh_lost)
  );

  assign go_shift  = ((op == OP_SHL) || (op == OP_SHR)) && (amt_in != '0);
  assign last_step = (state_q == ST_SHIFT) && (cnt_q == SHAMT_W'(1));

  always_comb begin
    fin_flags.carry    = sh_last;
    fin_flags.overflow = !shr_q && (sticky_q || sh_lost);
    fin_flags.zero     = (sh_val == '0);
    fin_flags.negative = sh_val[MSB];
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      work_q   <= '0;
      cnt_q    <= '0;
      shr_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else if (accept && go_shift) begin
      work_q   <= a;
      cnt_q    <= amt_in;
      shr_q    <= (op == OP_SHR);
      sticky_q <= 1'b0;
    end else if (state_q == ST_SHIFT) begin
      work_q   <= sh_val;
      cnt_q    <= cnt_q - SHAMT_W'(1);
      sticky_q <= sticky_q | sh_lost;
    end
  end
`endif

  // Subtract reuses the adder as a + ~b + !borrow_in.
  always_comb begin
    opnd_b    = (op == OP_SUB) ? ~b : b;
    cin_eff   = (op == OP_SUB) ? ~cin : cin;
    sum       = {1'b0, a} + {1'b0, opnd_b} + {{WIDTH{1'b0}}, cin_eff};
    imm_res   = '0;
    imm_carry = 1'b0;
    imm_ovf   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        imm_res   = sum[WIDTH-1:0];
        imm_carry = sum[WIDTH];
        imm_ovf   = (a[MSB] == opnd_b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_AND: imm_res = a & b;
      OP_OR:  imm_res = a | b;
      OP_XOR: imm_res = a ^ b;
      OP_NOT: imm_res = ~a;
      default: begin
`ifdef ALU_BARREL_EN
        imm_res   = sh_val;
        imm_carry = sh_last;
        imm_ovf   = (op == OP_SHL) && sh_lost;
`else
        imm_res   = a;  // iterative shifts only finish here when the amount is 0
`endif
      end
    endcase
    imm_flags.carry    = imm_carry;
    imm_flags.overflow = imm_ovf;
    imm_flags.zero     = (imm_res == '0);
    imm_flags.negative = imm_res[MSB];
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (accept && !go_shift) begin
      result_q <= imm_res;
      flags_q  <= imm_flags;
    end
`ifndef ALU_BARREL_EN
    else if (last_step) begin
      result_q <= sh_val;
      flags_q  <= fin_flags;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (clear) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = go_shift ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
`ifdef ALU_BARREL_EN
        state_d = ST_IDLE;
`else
        if (last_step) state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (accept)         state_d = go_shift ? ST_SHIFT : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // in_ready looks at out_ready only in DONE, giving back-to-back throughput.
  always_comb begin
    out_valid = (state_q == ST_DONE);
    in_ready  = ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready)) && !clear;
  end

  assign result   = result_q;
  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign zero     = flags_q.zero;
  assign negative = flags_q.negative;

endmodule
